// File: rtl/tx3tx3tx3trl_pkg.sv
// Shared types and helpers for the s-box round engine: FSM state, majority,
// the 3x3 s-box, and default parameter values.
package tx3tx3tx3trl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_MAX_ROUNDS = 16;
    localparam int DEF_ROT        = 1;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Group bit 0 is a, bit 1 is b, bit 2 is c; the result uses the same ordering.
    function automatic logic [2:0] sbox3(input logic [2:0] g);
        logic a;
        logic b;
        logic c;
        a = g[0];
        b = g[1];
        c = g[2];
        return {maj(~a, b, ~c), maj(a, b, ~c), maj(~a, b, c)};
    endfunction

endpackage

// File: rtl/sbox_round.sv
// One combinational permutation round: s-box layer (tail bits pass through),
// rotation toward lower indices, then XOR with key and zero-extended round index.
module sbox_round
    import tx3tx3tx3trl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROT        = DEF_ROT,
    parameter int RCW        = $clog2(DEF_MAX_ROUNDS + 1)
) (
    input  logic [DATA_WIDTH-1:0] state,
    input  logic [DATA_WIDTH-1:0] key,
    input  logic [RCW-1:0]        round_idx,
    output logic [DATA_WIDTH-1:0] next_state
);

    localparam int GROUPS = DATA_WIDTH / 3;

    logic [DATA_WIDTH-1:0] sub;
    logic [DATA_WIDTH-1:0] rot;
    logic [DATA_WIDTH-1:0] rc;

    always_comb begin
        sub = state;
        for (int g = 0; g < GROUPS; g++) begin
            sub[3*g +: 3] = sbox3(state[3*g +: 3]);
        end
    end

    // rot[j] = sub[(j + ROT) mod DATA_WIDTH]
    always_comb begin
        if (ROT == 0) begin
            rot = sub;
        end else begin
            rot = (sub >> ROT) | (sub << (DATA_WIDTH - ROT));
        end
    end

    assign rc         = DATA_WIDTH'(round_idx);
    assign next_state = rot ^ key ^ rc;

endmodule

// File: rtl/sbox_round_engine.sv
// Iterative multi-round s-box permutation engine with valid/ready ports.
// Define SBOX_ROUND_ENGINE_UNROLL2_EN to apply two chained rounds per RUN cycle.
module sbox_round_engine
    import tx3tx3tx3trl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
    parameter int ROT        = DEF_ROT,
    parameter int RCW        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] key_i,
    input  logic [RCW-1:0]        rounds_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o
);

    localparam logic [RCW-1:0] MAX_R = RCW'(MAX_ROUNDS);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] key_q;
    logic [RCW-1:0]        rounds_q;
    logic [RCW-1:0]        cnt_q;

    logic [RCW-1:0]        eff_rounds;
    logic                  accept;
    logic                  last_step;
    logic [DATA_WIDTH-1:0] step_data;
    logic [RCW-1:0]        cnt_next;
    logic [DATA_WIDTH-1:0] round0;

    assign eff_rounds = (rounds_i > MAX_R) ? MAX_R : rounds_i;
    assign accept     = (state_q == IDLE) && in_valid_i;

    sbox_round #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROT        (ROT),
        .RCW        (RCW)
    ) u_round0 (
        .state      (data_q),
        .key        (key_q),
        .round_idx  (cnt_q),
        .next_state (round0)
    );

`ifdef SBOX_ROUND_ENGINE_UNROLL2_EN
    localparam int CW = RCW + 1;

    logic [DATA_WIDTH-1:0] round1;
    logic                  one_left;
    logic                  two_left;

    sbox_round #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROT        (ROT),
        .RCW        (RCW)
    ) u_round1 (
        .state      (round0),
        .key        (key_q),
        .round_idx  (cnt_q + RCW'(1)),
        .next_state (round1)
    );

    // An odd round count finishes with a single round on the last cycle.
    assign one_left  = ({1'b0, cnt_q} + CW'(1)) == {1'b0, rounds_q};
    assign two_left  = ({1'b0, cnt_q} + CW'(2)) == {1'b0, rounds_q};
    assign last_step = one_left || two_left;
    assign step_data = one_left ? round0 : round1;
    assign cnt_next  = cnt_q + RCW'(2);
`else
    assign last_step = (cnt_q == (rounds_q - RCW'(1)));
    assign step_data = round0;
    assign cnt_next  = cnt_q + RCW'(1);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid_i) state_d = (eff_rounds == '0) ? DONE : RUN;
            RUN:  if (last_step) state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        data_o      = (state_q == DONE) ? data_q : '0;
    end

    // Operands are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q   <= '0;
            key_q    <= '0;
            rounds_q <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            data_q   <= data_i;
            key_q    <= key_i;
            rounds_q <= eff_rounds;
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            data_q   <= step_data;
            cnt_q    <= cnt_next;
        end
    end

endmodule

// File: doc/sbox_round_engine.md
Name: sbox_round_engine

Overview:
- Iterative multi-round permutation core built on the 3x3 s-box layer.
- Accepts one DATA_WIDTH block and a key over a valid/ready input port.
- Applies a per-transaction number of rounds, one round per cycle. Each round is s-box layer, then rotation, then XOR with key and round constant.
- Returns the result over a valid/ready output port. Sits between the datapath front-end and the output mixer.

Parameters:
- DATA_WIDTH, 48, state width in bits (>= 3; any value, not only multiples of 3).
- MAX_ROUNDS, 16, upper bound on rounds per transaction.
- ROT, 1, rotation amount per round (0 <= ROT < DATA_WIDTH).
- RCW, $clog2(MAX_ROUNDS+1), width of rounds_i and of the round-constant field; must be <= DATA_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  engine can accept a block.
- data_i  in  DATA_WIDTH  input block.
- key_i  in  DATA_WIDTH  round key, sampled at acceptance.
- rounds_i  in  RCW  requested round count, sampled at acceptance.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- data_o  out  DATA_WIDTH  result block.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, data_o=0, round counter=0, latched key/rounds=0.
- S-box group g covers bits a=3g, b=3g+1, c=3g+2:
  - y_a = maj(~a, b, c)
  - y_b = maj(a, b, ~c)
  - y_c = maj(~a, b, ~c)
  - maj(x,y,z) = xy | xz | yz.
  - Examples: 000->001, 111->110.
- Tail bits (DATA_WIDTH % 3 of them, the highest indices) pass through the s-box layer unchanged.
- Rotation: r[j] = s[(j+ROT) mod DATA_WIDTH].
- Round function: next = r XOR key XOR rc, where rc = zero-extended round index. Round index bit k maps to state bit k. Index runs 0..R-1.
- Effective rounds R = min(rounds_i, MAX_ROUNDS).
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready_o=1. On in_valid_i & in_ready_o, latch data_i/key_i/R and clear the counter. Go to DONE if R==0, else RUN.
  - RUN: in_ready_o=0. Each cycle apply one round and increment the counter. When counter==R-1, apply the final round and go to DONE.
  - DONE: out_valid_o=1, data_o=state. Hold data_o stable while out_valid_o & ~out_ready_i. On out_ready_i, go to IDLE.
- Latency: with acceptance on edge 0, out_valid_o is high from the cycle after edge R (for R==0, the cycle after edge 0).
- Throughput: one transaction in flight. No new acceptance until DONE is left; in_ready_o is low in RUN and DONE.
- in_valid_i while busy is ignored; the source must hold it.
- Changes on key_i/rounds_i after acceptance have no effect.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid_o is produced.
- out_ready_i high before DONE has no effect.

Optional Feature:
- Macro: SBOX_ROUND_ENGINE_UNROLL2_EN.
- Defined:
  - RUN applies two rounds per cycle (index k, then k+1), chained combinationally.
  - If R is odd, the final cycle applies one round only.
  - Latency becomes ceil(R/2) cycles from acceptance to out_valid_o.
  - Results are bit-identical to the undefined build.
- Undefined: one round per cycle, as above.

Decomposition:
- Shared package (tx3tx3tx3trl_pkg):
  - FSM state enum (IDLE/RUN/DONE).
  - maj function.
  - 3x3 s-box function on a 3-bit group.
  - Default parameter constants.
- Sub-module sbox_round: purely combinational, one full round (s-box layer with tail pass-through, rotation, key XOR, rc XOR). Parameters DATA_WIDTH, ROT, RCW; inputs state, key, round index.
- The engine instantiates one sbox_round, or two chained under UNROLL2.

Test Plan:
- Zero-state round: DATA_WIDTH=6, ROT=1, key=0, data=000000, rounds=1 -> data_o bits[0:5]=0,1,0,0,1,0; out_valid_o the cycle after edge 1.
- Zero rounds: rounds=0, data=101101 -> out_valid_o one cycle after acceptance, data_o=101101.
- Tail pass-through: DATA_WIDTH=7, ROT=0, key=0, rounds=1, data bits 0,0,0,1,1,1,1 -> data_o=0,0,1,1,1,0,1.
- Clamp: MAX_ROUNDS=16, rounds=31 -> out_valid_o after exactly 16 rounds; result equal to the rounds=16 run.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> out_valid_o and data_o stable, in_ready_o=0, then IDLE one cycle after out_ready_i=1.
- Reset mid-RUN: assert rst_ni=0 at round 3 of 8 -> all outputs return to reset values asynchronously; the next transaction after reset produces the correct result.
